// File: rtl/debug_mem_dumper.sv
// Debug-side memory dumper: sweeps the data-memory debug read port and streams
// each captured word to the UART transmitter as four bytes, MSB first.
module debug_mem_dumper #(
    parameter int unsigned MEM_WORDS = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ADDR_STEP = 32'd4,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] mem_data,
    output logic        debug_on,
    output logic [31:0] debug_addr,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    // state | meaning
    // IDLE  | waiting for start, all outputs quiet
    // ADDR  | debug override on, address set to BASE_ADDR
    // WAIT  | read-latency wait, RD_LAT cycles
    // LATCH | capture mem_data into the byte shifter
    // SEND  | present bytes MSB first over valid/ready
    // NEXT  | step to the next word address
    // DONE  | one-cycle completion pulse
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WAIT, S_LATCH, S_SEND, S_NEXT, S_DONE
    } state_e;

    localparam logic [15:0] LAST_WORD  = 16'(MEM_WORDS - 1);
    localparam logic [2:0]  WAIT_LAST  = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;
    localparam state_e      AFTER_ADDR = (RD_LAT > 0) ? S_WAIT : S_LATCH;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] shift_q, shift_d;
    logic [15:0] word_q, word_d;
    logic [2:0]  wait_q, wait_d;
    logic [1:0]  byte_q, byte_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= BASE_ADDR;
            shift_q <= 32'h0;
            word_q  <= 16'h0;
            wait_q  <= 3'h0;
            byte_q  <= 2'h0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            wait_q  <= wait_d;
            byte_q  <= byte_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        shift_d = shift_q;
        word_d  = word_q;
        wait_d  = wait_q;
        byte_d  = byte_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_ADDR;
            end
            S_ADDR: begin
                addr_d  = BASE_ADDR;
                word_d  = 16'h0;
                wait_d  = 3'h0;
                state_d = AFTER_ADDR;
            end
            S_WAIT: begin
                wait_d = wait_q + 3'd1;
                if (wait_q == WAIT_LAST) state_d = S_LATCH;
            end
            S_LATCH: begin
                shift_d = mem_data;
                byte_d  = 2'h0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (tx_ready) begin
                    shift_d = {shift_q[23:0], 8'h00};
                    byte_d  = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        if (word_q == LAST_WORD) begin
                            state_d = S_DONE;
                            addr_d  = BASE_ADDR;
                        end else begin
                            state_d = S_NEXT;
                        end
                    end
                end
            end
            S_NEXT: begin
                addr_d  = addr_q + ADDR_STEP;
                word_d  = word_q + 16'd1;
                wait_d  = 3'h0;
                state_d = AFTER_ADDR;
            end
            S_DONE: begin
                addr_d  = BASE_ADDR;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Override stays asserted across word boundaries so the memory never leaves read mode mid-dump.
    assign debug_on   = (state_q != S_IDLE) && (state_q != S_DONE);
    assign busy       = debug_on;
    assign tx_valid   = (state_q == S_SEND);
    assign tx_data    = tx_valid ? shift_q[31:24] : 8'h00;
    assign done       = (state_q == S_DONE);
    assign debug_addr = addr_q;

endmodule

// File: tb/tb_debug_mem_dumper.sv
// Self-checking bench for debug_mem_dumper: two instances (base 0 / RD_LAT 1 and
// wrapping base / RD_LAT 0) checked against a byte-stream reference model.
module tb_debug_mem_dumper;

    localparam int          A_WORDS = 2;
    localparam logic [31:0] A_BASE  = 32'h0000_0000;
    localparam int          A_LAT   = 1;
    localparam int          B_WORDS = 2;
    localparam logic [31:0] B_BASE  = 32'hFFFF_FFFC;
    localparam int          B_LAT   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, tx_ready, start_a, start_b;
    logic [31:0] mem_a, mem_b;
    logic [31:0] mem_arr [4];
    bit          sel;

    logic        a_debug_on, a_tx_valid, a_busy, a_done;
    logic [31:0] a_addr;
    logic [7:0]  a_tx_data;
    logic        b_debug_on, b_tx_valid, b_busy, b_done;
    logic [31:0] b_addr;
    logic [7:0]  b_tx_data;

    debug_mem_dumper #(.MEM_WORDS(A_WORDS), .BASE_ADDR(A_BASE), .ADDR_STEP(32'd4), .RD_LAT(A_LAT)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .mem_data(mem_a),
        .debug_on(a_debug_on), .debug_addr(a_addr), .tx_data(a_tx_data),
        .tx_valid(a_tx_valid), .tx_ready(tx_ready), .busy(a_busy), .done(a_done)
    );

    debug_mem_dumper #(.MEM_WORDS(B_WORDS), .BASE_ADDR(B_BASE), .ADDR_STEP(32'd4), .RD_LAT(B_LAT)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .mem_data(mem_b),
        .debug_on(b_debug_on), .debug_addr(b_addr), .tx_data(b_tx_data),
        .tx_valid(b_tx_valid), .tx_ready(tx_ready), .busy(b_busy), .done(b_done)
    );

    // Memory models: one-cycle registered read for A, combinational read for B.
    always @(posedge clk) mem_a <= mem_arr[a_addr[3:2]];
    assign mem_b = mem_arr[b_addr[3:2]];

    logic        obs_debug_on, obs_tx_valid, obs_busy, obs_done;
    logic [31:0] obs_addr;
    logic [7:0]  obs_tx_data;
    assign obs_debug_on = sel ? b_debug_on : a_debug_on;
    assign obs_tx_valid = sel ? b_tx_valid : a_tx_valid;
    assign obs_busy     = sel ? b_busy     : a_busy;
    assign obs_done     = sel ? b_done     : a_done;
    assign obs_addr     = sel ? b_addr     : a_addr;
    assign obs_tx_data  = sel ? b_tx_data  : a_tx_data;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ready_mode: 0 = always ready, 1 = random ready.
    task automatic dump(input int ready_mode, input int stall_idx, input int stall_len,
                        input bit poke_start, input int rst_idx);
        int          words, lat, cyc, last_xfer, done_cnt, done_cyc, stall_cnt, exp_cyc;
        logic [31:0] base, a, w;
        logic [7:0]  exp_q[$];
        logic [7:0]  got_q[$];
        logic [31:0] exp_addr[$];
        logic [31:0] got_addr[$];
        bit          prev_valid, prev_xfer, xfer, finished, poked;
        logic [7:0]  prev_data;

        words = sel ? B_WORDS : A_WORDS;
        lat   = sel ? B_LAT : A_LAT;
        base  = sel ? B_BASE : A_BASE;
        for (int i = 0; i < words; i++) begin
            a = base + 32'(i) * 32'd4;
            w = mem_arr[a[3:2]];
            exp_addr.push_back(a);
            for (int b = 3; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
        end

        cyc = 0; last_xfer = 0; done_cnt = 0; done_cyc = 0; stall_cnt = 0;
        prev_valid = 0; prev_xfer = 0; finished = 0; poked = 0; prev_data = 8'h00;
        start_a = !sel;
        start_b = sel;
        while (!finished && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start_a = 1'b0;
            start_b = 1'b0;
            if (poke_start && !poked && got_q.size() == 1 && obs_tx_valid) begin
                poked   = 1;
                start_a = !sel;
                start_b = sel;
            end
            tx_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall_idx >= 0 && got_q.size() == stall_idx && stall_cnt < stall_len &&
                (stall_cnt > 0 || obs_tx_valid)) begin
                tx_ready = 1'b0;
                stall_cnt++;
                chk("stall_valid", 32'(obs_tx_valid), 32'd1);
                chk("stall_data", 32'(obs_tx_data), 32'(exp_q[stall_idx]));
            end
            if (rst_idx >= 0 && got_q.size() == rst_idx && obs_tx_valid) begin
                tx_ready = 1'b0;
                rst = 1'b0;
                @(negedge clk);
                chk("rst_tx_valid", 32'(obs_tx_valid), 32'd0);
                chk("rst_debug_on", 32'(obs_debug_on), 32'd0);
                chk("rst_busy", 32'(obs_busy), 32'd0);
                chk("rst_addr", obs_addr, base);
                chk("rst_tx_data", 32'(obs_tx_data), 32'd0);
                rst = 1'b1;
                return;
            end
            if (prev_valid && !prev_xfer) begin
                chk("hold_valid", 32'(obs_tx_valid), 32'd1);
                chk("hold_data", 32'(obs_tx_data), 32'(prev_data));
            end
            if (obs_tx_valid && !prev_valid) begin
                exp_cyc = (got_q.size() == 0) ? 3 + lat : last_xfer + 3 + lat;
                chk("valid_latency", 32'(cyc), 32'(exp_cyc));
            end
            if (obs_done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_timing", 32'(cyc), 32'(last_xfer + 1));
                chk("done_bytes", 32'(got_q.size()), 32'(exp_q.size()));
                chk("done_debug_on", 32'(obs_debug_on), 32'd0);
                chk("done_busy", 32'(obs_busy), 32'd0);
                chk("done_addr", obs_addr, base);
            end else if (done_cnt == 0) begin
                chk("active_debug_on", 32'(obs_debug_on), 32'd1);
                chk("active_busy", 32'(obs_busy), 32'd1);
            end else begin
                chk("post_busy", 32'(obs_busy), 32'd0);
                chk("post_tx_valid", 32'(obs_tx_valid), 32'd0);
            end
            if (obs_debug_on && (got_addr.size() == 0 || got_addr[$] !== obs_addr))
                got_addr.push_back(obs_addr);
            xfer = obs_tx_valid && tx_ready;
            if (xfer) begin
                got_q.push_back(obs_tx_data);
                last_xfer = cyc;
            end
            prev_valid = obs_tx_valid;
            prev_xfer  = xfer;
            prev_data  = obs_tx_data;
            if (done_cnt > 0 && cyc >= done_cyc + 3) finished = 1;
        end

        chk("finished", 32'(finished), 32'd1);
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("byte_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk("byte", 32'(got_q[i]), 32'(exp_q[i]));
        chk("addr_count", 32'(got_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++)
            chk("addr", got_addr[i], exp_addr[i]);
    endtask

    initial begin
        rst = 1'b0; start_a = 1'b1; start_b = 1'b1; tx_ready = 1'b0; sel = 0;
        for (int i = 0; i < 4; i++) mem_arr[i] = 32'h0;

        repeat (2) begin
            @(negedge clk);
            chk("reset_debug_on", 32'(a_debug_on), 32'd0);
            chk("reset_tx_valid", 32'(a_tx_valid), 32'd0);
            chk("reset_busy", 32'(a_busy), 32'd0);
            chk("reset_done", 32'(a_done), 32'd0);
            chk("reset_addr", a_addr, 32'h0);
            chk("reset_b_addr", b_addr, B_BASE);
            chk("reset_b_debug_on", 32'(b_debug_on), 32'd0);
        end
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        @(negedge clk);

        mem_arr[0] = 32'h1234_5678;
        mem_arr[1] = 32'hDEAD_BEEF;
        sel = 0;
        dump(0, -1, 0, 0, -1);
        dump(0, 1, 5, 0, -1);
        dump(0, -1, 0, 1, -1);
        dump(0, -1, 0, 0, 2);
        dump(0, -1, 0, 0, -1);

        sel = 1;
        mem_arr[3] = 32'hCAFE_F00D;
        dump(0, -1, 0, 0, -1);
        dump(0, 3, 2, 0, -1);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 4; i++) mem_arr[i] = $urandom();
            sel = r[0];
            dump(1, -1, 0, 0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
